// File: rtl/mem_writeback_pkg.sv
// rtl/mem_writeback_pkg.sv - shared types and constants for the MEM/WB stage
// Purpose: memory-access FSM state type, load/store funct3 encodings and the
//          alignment check shared by the stage and its helpers.
// Ports:   none (package).
package mem_writeback_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE    = 2'd0,
    MEM_REQ     = 2'd1,
    MEM_RD_WAIT = 2'd2
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size comes from funct3[1:0]; any size code other than byte or
  // half is treated as a word, so it must be word aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = a[0];
      default: misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - lane select and sign/zero extension of load data
// Purpose: turns a raw 32-bit memory word into the register value for a load.
// Ports:   funct3  in  3   load width/sign
//          addr_lo in  2   byte offset of the access
//          rdata   in  32  word returned by data memory
//          data    out 32  extended load value
module load_align
  import mem_writeback_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Unknown encodings fall back to a plain word load.
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_writeback.sv
// rtl/mem_writeback.sv - MEM+WB stage of the RV32I core
// Purpose: issues loads/stores on a valid/ready data port, stalls upstream
//          while an access is outstanding, and registers the writeback value.
// Ports:   clk, rst_n                   clock, async active-low reset
//          ex_*                         EX result and control (held by mem_stall)
//          mem_stall                    hold IF/ID/EX this cycle
//          dmem_req/we/addr/wdata/be    request to data memory
//          dmem_ready/rvalid/rdata      accept, read-valid and read data
//          writedata/write_rd/wb_RegWrite  register-file write port
//          mem_misalign, mem_fault      1-cycle error pulses
module mem_writeback
  import mem_writeback_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_rs2_data,
  input  logic [4:0]  ex_rd,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_MemToReg,
  input  logic        ex_RegWrite,
  input  logic        ex_MemRead,
  input  logic        ex_MemWrite,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] writedata,
  output logic [4:0]  write_rd,
  output logic        wb_RegWrite,
  output logic        mem_misalign,
  output logic        mem_fault
);

  localparam int TW = (DMEM_TIMEOUT > 2) ? $clog2(DMEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((DMEM_TIMEOUT > 0) ? DMEM_TIMEOUT - 1 : 0);
  localparam logic TO_EN = (DMEM_TIMEOUT != 0);

  mem_state_t    state_q, state_d;
  logic [TW-1:0] cnt_q;
  logic          mem_op, alu_done, mis, mis_now, busy, complete, abort, to_hit;
  logic          load_wb;
  logic [31:0]   load_val;

  assign mem_op   = ex_valid & (ex_MemRead | ex_MemWrite);
  assign alu_done = ex_valid & ~(ex_MemRead | ex_MemWrite) & (state_q == MEM_IDLE);
  assign mis      = misaligned(ex_funct3[1:0], ex_alu_result[1:0]);
  assign to_hit   = TO_EN && (cnt_q == TO_LAST);
  assign load_wb  = (ex_MemRead | ex_MemToReg) & ~ex_MemWrite;

  load_align u_load_align (
    .funct3  (ex_funct3),
    .addr_lo (ex_alu_result[1:0]),
    .rdata   (dmem_rdata),
    .data    (load_val)
  );

  always_comb begin
    state_d  = state_q;
    dmem_req = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    mis_now  = 1'b0;
    busy     = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (mem_op) begin
          if (mis) begin
            mis_now = 1'b1;
          end else begin
            busy     = 1'b1;
            dmem_req = 1'b1;
            if (dmem_ready && (ex_MemWrite || dmem_rvalid)) complete = 1'b1;
            else if (dmem_ready)                            state_d  = MEM_RD_WAIT;
            else                                            state_d  = MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        busy     = 1'b1;
        dmem_req = 1'b1;
        if (dmem_ready && (ex_MemWrite || dmem_rvalid)) complete = 1'b1;
        else if (dmem_ready)                            state_d  = MEM_RD_WAIT;
      end
      MEM_RD_WAIT: begin
        busy = 1'b1;
        if (dmem_rvalid) complete = 1'b1;
      end
      default: state_d = MEM_IDLE;
    endcase
    if (complete) state_d = MEM_IDLE;
    // A completion in the last allowed cycle wins over the timeout.
    if ((state_q != MEM_IDLE) && !complete && to_hit) begin
      abort   = 1'b1;
      state_d = MEM_IDLE;
    end
  end

  // The stall drops in the abort cycle so the dropped instruction leaves EX
  // instead of being reissued from IDLE.
  assign mem_stall = busy & ~complete & ~abort;

  always_comb begin
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_be    = '0;
    if (dmem_req) begin
      dmem_we   = ex_MemWrite;
      dmem_addr = {ex_alu_result[31:2], 2'b00};
      dmem_be   = 4'b1111;
      if (ex_MemWrite) begin
        case (ex_funct3[1:0])
          2'b00: begin
            dmem_be    = 4'b0001 << ex_alu_result[1:0];
            dmem_wdata = {4{ex_rs2_data[7:0]}};
          end
          2'b01: begin
            dmem_be    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
            dmem_wdata = {2{ex_rs2_data[15:0]}};
          end
          default: dmem_wdata = ex_rs2_data;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= MEM_IDLE;
      cnt_q        <= '0;
      writedata    <= '0;
      write_rd     <= '0;
      wb_RegWrite  <= 1'b0;
      mem_misalign <= 1'b0;
      mem_fault    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_misalign <= mis_now;
      mem_fault    <= abort;
      wb_RegWrite  <= 1'b0;
      if ((state_q == MEM_IDLE) && (state_d != MEM_IDLE)) begin
        cnt_q <= '0;
      end else if ((state_q != MEM_IDLE) && TO_EN) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (alu_done) begin
        writedata   <= ex_alu_result;
        write_rd    <= ex_rd;
        wb_RegWrite <= ex_RegWrite && (ex_rd != 5'd0);
      end else if (complete) begin
        writedata   <= load_wb ? load_val : ex_alu_result;
        write_rd    <= ex_rd;
        wb_RegWrite <= ex_RegWrite && !ex_MemWrite && (ex_rd != 5'd0);
      end
    end
  end

endmodule
